// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard/trap controller: FSM states,
// exception flag positions and the trap-cause priority encoder.
package hazard_ctrl_pkg;

  localparam int EXCEPTION_WIDTH = 4;

  // Flag positions inside ex_exception / trap_cause, ordered {ILLEGAL, ECALL, EBREAK, MRET}
  localparam int EXC_ILLEGAL = 3;
  localparam int EXC_ECALL   = 2;
  localparam int EXC_EBREAK  = 1;
  localparam int EXC_MRET    = 0;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_t;

  // Reduce a set of simultaneous exception flags to a single one-hot winner
  function automatic logic [EXCEPTION_WIDTH-1:0] exc_priority(
    input logic [EXCEPTION_WIDTH-1:0] flags
  );
    logic [EXCEPTION_WIDTH-1:0] win;
    win = '0;
    if (flags[EXC_ILLEGAL])     win[EXC_ILLEGAL] = 1'b1;
    else if (flags[EXC_ECALL])  win[EXC_ECALL]   = 1'b1;
    else if (flags[EXC_EBREAK]) win[EXC_EBREAK]  = 1'b1;
    else if (flags[EXC_MRET])   win[EXC_MRET]    = 1'b1;
    return win;
  endfunction

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register marking a
// long-latency result that has not yet been written back. x0 never pends.
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [REG_AW-1:0]   set_rd,
  input  logic                clr_en,
  input  logic [REG_AW-1:0]   clr_rd,
  input  logic                flush,
  output logic [NUM_REGS-1:0] pend
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_n;

  // Next mask: clear first so a same-register set overrides it; a flush discards everything
  always_comb begin
    pend_n = pend_q;
    if (clr_en) pend_n[clr_rd] = 1'b0;
    if (set_en) pend_n[set_rd] = 1'b1;
    if (flush)  pend_n = '0;
    pend_n[0] = 1'b0;
  end

  // Mask register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_n;
  end

  assign pend = pend_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and trap controller. Stalls decode on RAW/WAW hazards
// against outstanding long-latency producers, and sequences a trap by
// draining in-flight loads before a one-cycle flush and pc redirect.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// ST_IDLE  | normal operation, watching execute for an exception
// ST_DRAIN | trap captured, waiting for pending loads (or the timeout)
// ST_FLUSH | one cycle: flush pipeline, redirect to mtvec/mepc
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       id_valid,
  input  logic [4:0]                 id_rs1,
  input  logic [4:0]                 id_rs2,
  input  logic                       id_rs1_used,
  input  logic                       id_rs2_used,
  input  logic [4:0]                 id_rd,
  input  logic                       id_rd_wr,
  input  logic                       id_long,
  input  logic                       id_issue,
  input  logic                       ex_valid,
  input  logic [EXCEPTION_WIDTH-1:0] ex_exception,
  input  logic [31:0]                ex_pc,
  input  logic                       wb_valid,
  input  logic [4:0]                 wb_rd,
  input  logic [31:0]                mtvec,
  input  logic [31:0]                mepc,
  output logic                       hz_stall,
  output logic                       hz_flush,
  output logic                       redirect_valid,
  output logic [31:0]                redirect_pc,
  output logic [EXCEPTION_WIDTH-1:0] trap_cause,
  output logic [31:0]                trap_epc,
  output logic                       busy,
  output logic                       drain_timeout
);

  // At least one counter bit even for degenerate timeouts
  localparam int CW = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  hz_state_t           state;
  logic [CW-1:0]       drain_cnt;
  logic                busy_q;
  logic                flush_q;
  logic [NUM_REGS-1:0] pend;
  logic                sb_set;
  logic                raw_hazard;

  assign sb_set = id_issue && id_rd_wr && id_long && (id_rd != 5'd0);

  hazard_scoreboard u_scoreboard (
    .clk    (clk),
    .rst_n  (rst_n),
    .set_en (sb_set),
    .set_rd (id_rd),
    .clr_en (wb_valid),
    .clr_rd (wb_rd),
    .flush  (flush_q),
    .pend   (pend)
  );

  // Decode hazard check uses the registered mask, so a writeback releases the stall one cycle later
  always_comb begin
    raw_hazard = id_valid && ((id_rs1_used && pend[id_rs1]) ||
                              (id_rs2_used && pend[id_rs2]) ||
                              (id_rd_wr    && pend[id_rd]));
  end

  assign hz_stall       = busy_q || raw_hazard;
  assign busy           = busy_q;
  assign hz_flush       = flush_q;
  assign redirect_valid = flush_q;
  assign redirect_pc    = !flush_q ? 32'd0 : (trap_cause[EXC_MRET] ? mepc : mtvec);

  // Trap sequencer; busy/flush flags are registered alongside the state they mirror
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      drain_cnt     <= '0;
      trap_cause    <= '0;
      trap_epc      <= '0;
      drain_timeout <= 1'b0;
      busy_q        <= 1'b0;
      flush_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ex_valid && (|ex_exception)) begin
            trap_epc   <= ex_pc;
            trap_cause <= exc_priority(ex_exception);
            drain_cnt  <= '0;
            busy_q     <= 1'b1;
            state      <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt != CNT_LAST) drain_cnt <= drain_cnt + CNT_ONE;
          if (pend == '0) begin
            flush_q <= 1'b1;
            state   <= ST_FLUSH;
          end else if (drain_cnt == CNT_LAST) begin
            flush_q       <= 1'b1;
            drain_timeout <= 1'b1;
            state         <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          flush_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          flush_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: scoreboard stalls, trap drain/flush,
// cause priority, drain timeout and reset abort.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_rs1_used, id_rs2_used, id_rd_wr, id_long, id_issue;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_valid;
  logic [3:0]  ex_exception;
  logic [31:0] ex_pc;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] mtvec, mepc;
  logic        hz_stall, hz_flush, redirect_valid, busy, drain_timeout;
  logic [31:0] redirect_pc, trap_epc;
  logic [3:0]  trap_cause;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.DRAIN_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_wr(id_rd_wr), .id_long(id_long), .id_issue(id_issue),
    .ex_valid(ex_valid), .ex_exception(ex_exception), .ex_pc(ex_pc),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .mtvec(mtvec), .mepc(mepc),
    .hz_stall(hz_stall), .hz_flush(hz_flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .trap_cause(trap_cause), .trap_epc(trap_epc),
    .busy(busy), .drain_timeout(drain_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_wr = 0; id_long = 0; id_issue = 0;
    ex_valid = 0; ex_exception = 0; ex_pc = 0;
    wb_valid = 0; wb_rd = 0;
  endtask

  task automatic issue_long(input logic [4:0] rd);
    id_valid = 1; id_issue = 1; id_rd_wr = 1; id_long = 1; id_rd = rd;
  endtask

  int n;
  int redirects;

  initial begin
    idle_inputs();
    mtvec = 32'h80; mepc = 32'h200;
    rst_n = 0;
    #12;
    chk("rst_stall", hz_stall, 0);
    chk("rst_flush", hz_flush, 0);
    chk("rst_rvalid", redirect_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cause", trap_cause, 0);
    chk("rst_epc", trap_epc, 0);
    chk("rst_tmo", drain_timeout, 0);
    chk("rst_rpc", redirect_pc, 0);
    @(negedge clk);
    rst_n = 1;
    tick();

    // Scenario 1: RAW on x5 held until the cycle after writeback
    issue_long(5'd5);
    chk("s1_issue_nostall", hz_stall, 0);
    tick();
    idle_inputs();
    id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
    chk("s1_stall_a", hz_stall, 1);
    tick();
    chk("s1_stall_b", hz_stall, 1);
    wb_valid = 1; wb_rd = 5;
    chk("s1_stall_wb_cycle", hz_stall, 1);
    tick();
    wb_valid = 0;
    chk("s1_release", hz_stall, 0);

    // WAW on x7, and same-cycle set/clear where set wins
    idle_inputs();
    issue_long(5'd7);
    tick();
    idle_inputs();
    id_valid = 1; id_rd_wr = 1; id_rd = 7;
    chk("waw_stall", hz_stall, 1);
    issue_long(5'd7);
    wb_valid = 1; wb_rd = 7;
    tick();
    idle_inputs();
    id_valid = 1; id_rs2 = 7; id_rs2_used = 1;
    chk("set_wins", hz_stall, 1);
    wb_valid = 1; wb_rd = 7;
    tick();
    wb_valid = 0;
    chk("x7_release", hz_stall, 0);

    // Scenario 2: x0 never pends
    idle_inputs();
    issue_long(5'd0);
    tick();
    idle_inputs();
    id_valid = 1; id_rs1 = 0; id_rs1_used = 1; id_rs2 = 0; id_rs2_used = 1;
    chk("s2_x0_a", hz_stall, 0);
    tick();
    chk("s2_x0_b", hz_stall, 0);

    // Scenario 3: ECALL with one load pending, writeback in the third drain cycle
    idle_inputs();
    issue_long(5'd3);
    tick();
    idle_inputs();
    ex_valid = 1; ex_exception = 4'b0100; ex_pc = 32'h100;
    chk("s3_pre_busy", busy, 0);
    tick();
    idle_inputs();
    chk("s3_d1_busy", busy, 1);
    chk("s3_d1_stall", hz_stall, 1);
    chk("s3_d1_flush", hz_flush, 0);
    chk("s3_d1_rpc", redirect_pc, 0);
    tick();
    ex_valid = 1; ex_exception = 4'b1000; ex_pc = 32'h999;
    chk("s3_d2_busy", busy, 1);
    tick();
    idle_inputs();
    wb_valid = 1; wb_rd = 3;
    chk("s3_d3_busy", busy, 1);
    tick();
    idle_inputs();
    chk("s3_d4_busy", busy, 1);
    chk("s3_d4_flush", hz_flush, 0);
    tick();
    chk("s3_flush", hz_flush, 1);
    chk("s3_rvalid", redirect_valid, 1);
    chk("s3_rpc", redirect_pc, 32'h80);
    chk("s3_epc", trap_epc, 32'h100);
    chk("s3_cause", trap_cause, 4'b0100);
    chk("s3_tmo", drain_timeout, 0);
    tick();
    chk("s3_after_busy", busy, 0);
    chk("s3_after_flush", hz_flush, 0);
    chk("s3_after_rvalid", redirect_valid, 0);
    chk("s3_after_rpc", redirect_pc, 0);

    // Scenario 4: ILLEGAL beats MRET; MRET alone returns to mepc
    ex_valid = 1; ex_exception = 4'b1001; ex_pc = 32'h140;
    tick();
    idle_inputs();
    tick();
    chk("s4_flush_a", hz_flush, 1);
    chk("s4_cause_a", trap_cause, 4'b1000);
    chk("s4_rpc_a", redirect_pc, 32'h80);
    tick();
    ex_valid = 1; ex_exception = 4'b0001; ex_pc = 32'h180;
    tick();
    idle_inputs();
    tick();
    chk("s4_flush_b", hz_flush, 1);
    chk("s4_cause_b", trap_cause, 4'b0001);
    chk("s4_rpc_b", redirect_pc, 32'h200);
    chk("s4_epc_b", trap_epc, 32'h180);
    tick();
    ex_valid = 1; ex_exception = 4'b0011; ex_pc = 32'h1c0;
    tick();
    idle_inputs();
    tick();
    chk("s4_cause_c", trap_cause, 4'b0010);
    chk("s4_rpc_c", redirect_pc, 32'h80);
    tick();

    // Scenario 5: load never returns, drain times out after 8 cycles
    issue_long(5'd9);
    tick();
    idle_inputs();
    ex_valid = 1; ex_exception = 4'b0100; ex_pc = 32'h300;
    tick();
    idle_inputs();
    n = 0;
    while (!hz_flush && n < 20) begin
      n++;
      tick();
    end
    chk("s5_drain_cycles", n, 8);
    chk("s5_flush", hz_flush, 1);
    chk("s5_tmo", drain_timeout, 1);
    chk("s5_rpc", redirect_pc, 32'h80);
    tick();
    id_valid = 1; id_rs1 = 9; id_rs1_used = 1;
    chk("s5_mask_cleared", hz_stall, 0);
    chk("s5_tmo_sticky_a", drain_timeout, 1);
    tick();
    chk("s5_tmo_sticky_b", drain_timeout, 1);
    idle_inputs();

    // Scenario 6: reset in the middle of a drain aborts the trap
    issue_long(5'd4);
    tick();
    idle_inputs();
    ex_valid = 1; ex_exception = 4'b0100; ex_pc = 32'h400;
    tick();
    idle_inputs();
    id_valid = 1; id_rs1 = 4; id_rs1_used = 1;
    tick();
    chk("s6_pre_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_stall", hz_stall, 0);
    chk("s6_rst_flush", hz_flush, 0);
    chk("s6_rst_rvalid", redirect_valid, 0);
    chk("s6_rst_tmo", drain_timeout, 0);
    chk("s6_rst_epc", trap_epc, 0);
    chk("s6_rst_cause", trap_cause, 0);
    @(negedge clk);
    rst_n = 1;
    redirects = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (redirect_valid || hz_flush) redirects++;
    end
    chk("s6_no_redirect", redirects, 0);
    chk("s6_stall_after", hz_stall, 0);
    chk("s6_busy_after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
